// File: rtl/frame_window_downloader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_window_downloader
//  Brief    : Fetches a cropped, offset window out of a burst-addressed source
//             frame and streams it into the display FIFO as marker-delimited
//             (PIXEL_BITS+1)-bit words.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_window_downloader #(
    parameter int ADDR_WIDTH   = 21,
    parameter int BURST_WORDS  = 8,
    parameter int PIXEL_BITS   = 16,
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272,
    parameter int SRC_WIDTH    = 640,
    parameter int SRC_HEIGHT   = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [10:0]           x_off,
    input  logic [10:0]           y_off,
    output logic                  busy,
    input  logic                  queue_full,
    output logic [PIXEL_BITS:0]   queue_data,
    output logic                  wr_en,
    output logic                  read_rq,
    input  logic                  read_ack,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           read_data,
    input  logic                  rd_data_valid,
    output logic                  download_done
);

    localparam int c_PIX_PER_BURST = 2 * BURST_WORDS;
    localparam int c_BEAT_W        = $clog2(BURST_WORDS);
    localparam int c_PIX_W         = $clog2(c_PIX_PER_BURST);
    localparam int c_COL_W         = $clog2(FRAME_WIDTH);
    localparam int c_ROW_W         = $clog2(FRAME_HEIGHT + 1);

    localparam logic [c_COL_W-1:0]    c_COL_LAST     = c_COL_W'(FRAME_WIDTH - 1);
    localparam logic [c_ROW_W-1:0]    c_ROW_END      = c_ROW_W'(FRAME_HEIGHT);
    localparam logic [c_BEAT_W-1:0]   c_BEAT_LAST    = c_BEAT_W'(BURST_WORDS - 1);
    localparam logic [c_PIX_W-1:0]    c_PIX_LAST     = c_PIX_W'(c_PIX_PER_BURST - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_STRIDE   = ADDR_WIDTH'(SRC_WIDTH / 2);
    localparam logic [ADDR_WIDTH-1:0] c_BURST_STRIDE = ADDR_WIDTH'(BURST_WORDS);
    localparam logic [10:0]           c_MAX_X        = 11'(SRC_WIDTH - FRAME_WIDTH);
    localparam logic [10:0]           c_MAX_Y        = 11'(SRC_HEIGHT - FRAME_HEIGHT);

    localparam logic [PIXEL_BITS:0] c_MARK_FRAME = {1'b1, {PIXEL_BITS{1'b0}}};
    localparam logic [PIXEL_BITS:0] c_MARK_ROW   = {1'b1, PIXEL_BITS'(1)};
    localparam logic [PIXEL_BITS:0] c_MARK_END   = {(PIXEL_BITS + 1){1'b1}};

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FRAME_START = 4'd1,
        S_ROW_START   = 4'd2,
        S_REQ         = 4'd3,
        S_WAIT_ACK    = 4'd4,
        S_RECV        = 4'd5,
        S_DRAIN       = 4'd6,
        S_FRAME_END   = 4'd7,
        S_DONE        = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_ROW_W-1:0]      r_row;
    logic [c_COL_W-1:0]      r_col;
    logic [c_BEAT_W-1:0]     r_beat;
    logic [c_PIX_W-1:0]      r_pix;
    logic [ADDR_WIDTH-1:0]   r_row_addr;
    logic [ADDR_WIDTH-1:0]   r_burst_addr;
    logic                    r_abort_pend;
    logic [31:0]             r_buf [BURST_WORDS];

    logic [10:0]             w_x_even;
    logic [10:0]             w_x_eff;
    logic [10:0]             w_y_eff;
    logic [31:0]             w_y_words;
    logic [ADDR_WIDTH-1:0]   w_start_addr;
    logic [31:0]             w_buf_word;
    logic [PIXEL_BITS-1:0]   w_pixel;
    logic                    w_burst_last;

    // Clamp the requested offsets so the window stays inside the source frame
    // and derive the word address of the window's first pixel.
    always_comb begin
        w_x_even     = x_off & ~11'd1;
        w_x_eff      = (w_x_even > c_MAX_X) ? c_MAX_X : w_x_even;
        w_y_eff      = (y_off > c_MAX_Y) ? c_MAX_Y : y_off;
        w_y_words    = 32'(w_y_eff) * 32'(SRC_WIDTH / 2);
        w_start_addr = base_addr + ADDR_WIDTH'(w_y_words) + ADDR_WIDTH'(w_x_eff >> 1);
    end

    // Select the current pixel from the burst buffer; low half of a word comes first.
    always_comb begin
        w_buf_word   = r_buf[r_pix >> 1];
        w_pixel      = r_pix[0] ? w_buf_word[2*PIXEL_BITS-1:PIXEL_BITS] : w_buf_word[PIXEL_BITS-1:0];
        w_burst_last = rd_data_valid && (r_beat == c_BEAT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode; writes only happen on non-full cycles.
    always_comb begin
        w_state_next  = r_state;
        busy          = (r_state != S_IDLE);
        queue_data    = '0;
        wr_en         = 1'b0;
        read_rq       = 1'b0;
        read_addr     = '0;
        mem_rd_en     = 1'b0;
        download_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_next = S_FRAME_START;
                end
            end
            S_FRAME_START: begin
                queue_data = c_MARK_FRAME;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!queue_full) begin
                    wr_en        = 1'b1;
                    w_state_next = S_ROW_START;
                end
            end
            S_ROW_START: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (r_row == c_ROW_END) begin
                    w_state_next = S_FRAME_END;
                end else begin
                    queue_data = c_MARK_ROW;
                    if (!queue_full) begin
                        wr_en        = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                read_addr = r_burst_addr;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    read_rq      = 1'b1;
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // The grant is always honoured, even with an abort pending,
                // so the arbiter's burst is never left half-consumed.
                read_addr = r_burst_addr;
                if (read_ack) begin
                    mem_rd_en    = 1'b1;
                    w_state_next = S_RECV;
                end else begin
                    read_rq = 1'b1;
                end
            end
            S_RECV: begin
                if (w_burst_last) begin
                    w_state_next = (r_abort_pend || abort) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                queue_data = {1'b0, w_pixel};
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!queue_full) begin
                    wr_en = 1'b1;
                    if (r_col == c_COL_LAST) begin
                        w_state_next = S_ROW_START;
                    end else if (r_pix == c_PIX_LAST) begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_FRAME_END: begin
                queue_data = c_MARK_END;
                if (!queue_full) begin
                    wr_en        = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                download_done = 1'b1;
                w_state_next  = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Row/column/burst bookkeeping and address generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_beat       <= '0;
            r_pix        <= '0;
            r_row_addr   <= '0;
            r_burst_addr <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_row        <= '0;
                        r_col        <= '0;
                        r_row_addr   <= w_start_addr;
                        r_burst_addr <= w_start_addr;
                        r_abort_pend <= 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (read_ack) begin
                        r_beat <= '0;
                    end
                end
                S_RECV: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (rd_data_valid) begin
                        r_beat <= r_beat + 1'b1;
                    end
                    if (w_burst_last) begin
                        r_pix <= '0;
                    end
                end
                S_DRAIN: begin
                    if (wr_en) begin
                        if (r_col == c_COL_LAST) begin
                            // Leftover pixels of the final burst are simply dropped.
                            r_col        <= '0;
                            r_row        <= r_row + 1'b1;
                            r_row_addr   <= r_row_addr + c_ROW_STRIDE;
                            r_burst_addr <= r_row_addr + c_ROW_STRIDE;
                        end else begin
                            r_col <= r_col + 1'b1;
                            r_pix <= r_pix + 1'b1;
                            if (r_pix == c_PIX_LAST) begin
                                r_burst_addr <= r_burst_addr + c_BURST_STRIDE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Burst buffer capture; contents are don't-care outside RECV/DRAIN.
    always_ff @(posedge clk) begin
        if (r_state == S_RECV && rd_data_valid) begin
            r_buf[r_beat] <= read_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_window_downloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_window_downloader
//  Brief    : Self-checking bench: frame-level reference model of the window
//             fetch, memory/arbiter responders and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_window_downloader;

    localparam int AW = 21;
    localparam int BW = 8;
    localparam int PB = 16;
    localparam int FW = 20;
    localparam int FH = 3;
    localparam int SW = 40;
    localparam int SH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [10:0]   x_off = '0;
    logic [10:0]   y_off = '0;
    logic          busy;
    logic          queue_full = 1'b0;
    logic [PB:0]   queue_data;
    logic          wr_en;
    logic          read_rq;
    logic          read_ack = 1'b0;
    logic [AW-1:0] read_addr;
    logic          mem_rd_en;
    logic [31:0]   read_data = '0;
    logic          rd_data_valid = 1'b0;
    logic          download_done;

    frame_window_downloader #(
        .ADDR_WIDTH(AW), .BURST_WORDS(BW), .PIXEL_BITS(PB),
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SRC_WIDTH(SW), .SRC_HEIGHT(SH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .x_off(x_off), .y_off(y_off), .busy(busy),
        .queue_full(queue_full), .queue_data(queue_data), .wr_en(wr_en),
        .read_rq(read_rq), .read_ack(read_ack), .read_addr(read_addr),
        .mem_rd_en(mem_rd_en), .read_data(read_data),
        .rd_data_valid(rd_data_valid), .download_done(download_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [PB:0]   exp_q[$];
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] got_a[$];
    logic [PB:0]   got_first_pix;
    int            wr_cnt, rd_cnt, done_cnt, rq_cycles, ack_wait;
    int            ack_delay = 1;
    bit            full_rand, gaps, extra_beat, prev_mem_rd_en;
    bit            resp_pending;
    logic [AW-1:0] resp_addr;
    int            resp_left, resp_i;

    // Source memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return {a[15:0] + 16'h8000, a[15:0] ^ 16'h5A5A};
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: whole-frame word list and burst address list.
    task automatic setup(input int base, input int xo, input int yo);
        int ex, ey, wa, col;
        logic [31:0] w;
        ex = xo & ~1;
        if (ex > SW - FW) ex = SW - FW;
        ey = (yo > SH - FH) ? SH - FH : yo;
        exp_q.delete(); exp_a.delete(); got_a.delete();
        exp_q.push_back({1'b1, 16'h0000});
        for (int r = 0; r < FH; r++) begin
            exp_q.push_back({1'b1, 16'h0001});
            for (int c = 0; c < FW; c++) begin
                col = ex + c;
                wa = (base + (ey + r) * (SW / 2) + col / 2) % (1 << AW);
                w = mem(AW'(wa));
                exp_q.push_back({1'b0, (col % 2 == 1) ? w[31:16] : w[15:0]});
            end
            for (int b = 0; b < (FW + 2 * BW - 1) / (2 * BW); b++)
                exp_a.push_back(AW'((base + (ey + r) * (SW / 2) + ex / 2 + b * BW) % (1 << AW)));
        end
        exp_q.push_back({1'b1, 16'hFFFF});
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; rq_cycles = 0;
    endtask

    // Compare DUT outputs against the model (called mid-cycle on the falling edge).
    task automatic sample();
        if (!reset_n) begin
            chk_eq("reset_outputs", 64'({busy, wr_en, queue_data, read_rq, read_addr, mem_rd_en, download_done}), 64'd0);
            return;
        end
        if (wr_en) begin
            chk_eq("wr_while_full", 64'(queue_full), 64'd0);
            if (wr_cnt < exp_q.size()) chk_eq("queue_data", 64'(queue_data), 64'(exp_q[wr_cnt]));
            else chk_eq("extra_write", 64'(wr_cnt + 1), 64'(exp_q.size()));
            if (wr_cnt == 2) got_first_pix = queue_data;
            wr_cnt++;
        end
        if (read_rq) rq_cycles++;
        else if (!mem_rd_en) rq_cycles = 0;
        if (mem_rd_en) begin
            chk_eq("mem_rd_en_width", 64'(prev_mem_rd_en), 64'd0);
            chk_eq("read_rq_hold", 64'(rq_cycles), 64'(ack_delay));
            if (rd_cnt < exp_a.size()) chk_eq("read_addr", 64'(read_addr), 64'(exp_a[rd_cnt]));
            else chk_eq("extra_burst", 64'(rd_cnt + 1), 64'(exp_a.size()));
            got_a.push_back(read_addr);
            rd_cnt++;
            rq_cycles = 0;
            resp_pending = 1'b1;
            resp_addr = read_addr;
        end
        prev_mem_rd_en = mem_rd_en;
        if (download_done) done_cnt++;
    endtask

    // Arbiter, memory and FIFO-full stimulus (driven just after the rising edge).
    task automatic drive();
        queue_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        if (read_ack) read_ack = 1'b0;
        else if (read_rq) begin
            if (ack_wait >= ack_delay) begin read_ack = 1'b1; ack_wait = 0; end
            else ack_wait++;
        end else ack_wait = 0;
        rd_data_valid = 1'b0;
        if (resp_pending && resp_left == 0) begin
            resp_left = BW + (extra_beat ? 1 : 0);
            resp_i = 0;
            resp_pending = 1'b0;
        end
        if (resp_left > 0 && (!gaps || resp_i >= BW || $urandom_range(0, 1) == 1)) begin
            rd_data_valid = 1'b1;
            read_data = (resp_i < BW) ? mem(AW'(resp_addr + AW'(resp_i))) : 32'hDEADBEEF;
            resp_i++;
            resp_left--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; read_ack = 1'b0; rd_data_valid = 1'b0;
        resp_pending = 1'b0; resp_left = 0; ack_wait = 0; full_rand = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk_eq("idle_after_reset", 64'(busy), 64'd0);
    endtask

    task automatic pulse_start(input int base, input int xo, input int yo);
        base_addr = AW'(base); x_off = 11'(xo); y_off = 11'(yo);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_full(input int base, input int xo, input int yo, input bit fr,
                            input bit g, input int ad, input bit eb, input bit spur);
        full_rand = fr; gaps = g; ack_delay = ad; extra_beat = eb;
        setup(base, xo, yo);
        pulse_start(base, xo, yo);
        if (!fr) begin
            tick();
            chk_eq("first_write_latency", 64'(wr_cnt), 64'd1);
        end
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            tick();
            if (spur && i == 60) begin
                base_addr = '0; x_off = '0; y_off = '0; start = 1'b1;
            end else start = 1'b0;
        end
        start = 1'b0;
        chk_eq("done_timeout", 64'(done_cnt), 64'd1);
        repeat (3) tick();
        chk_eq("write_count", 64'(wr_cnt), 64'(exp_q.size()));
        chk_eq("burst_count", 64'(rd_cnt), 64'(exp_a.size()));
        chk_eq("done_pulses", 64'(done_cnt), 64'd1);
        chk_eq("busy_after_done", 64'(busy), 64'd0);
        full_rand = 1'b0; gaps = 1'b0; extra_beat = 1'b0; ack_delay = 1;
    endtask

    initial begin
        int n0;
        bit found;
        do_reset();

        // Nominal frame, no backpressure; pin the model with hand values.
        run_full(32'h100, 4, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk_eq("lit_write_count", 64'(wr_cnt), 64'd65);
        chk_eq("lit_addr0", 64'(got_a.size() > 0 ? got_a[0] : '0), 64'h12A);
        chk_eq("lit_addr1", 64'(got_a.size() > 1 ? got_a[1] : '0), 64'h132);
        chk_eq("lit_addr2", 64'(got_a.size() > 2 ? got_a[2] : '0), 64'h13E);
        chk_eq("lit_addr3", 64'(got_a.size() > 3 ? got_a[3] : '0), 64'h146);
        chk_eq("lit_addr4", 64'(got_a.size() > 4 ? got_a[4] : '0), 64'h152);
        chk_eq("lit_addr5", 64'(got_a.size() > 5 ? got_a[5] : '0), 64'h15A);
        chk_eq("lit_first_pixel", 64'(got_first_pix), 64'h05B70);

        // Random backpressure, gappy beats, an extra beat and a start while busy.
        run_full(32'h100, 4, 2, 1'b1, 1'b1, 1, 1'b1, 1'b1);

        // Offset clamping.
        run_full(32'h100, 25, 7, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk_eq("lit_clamp_addr0", 64'(got_a.size() > 0 ? got_a[0] : '0), 64'h16E);

        // Slow grant.
        run_full(32'h100, 4, 2, 1'b0, 1'b0, 10, 1'b0, 1'b0);

        // Abort on the third beat of the first burst.
        setup(32'h100, 4, 2);
        pulse_start(32'h100, 4, 2);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            tick();
            if (rd_data_valid && resp_i == 3) found = 1'b1;
        end
        chk_eq("abort_beat_reached", 64'(found), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("busy_while_absorbing", 64'(busy), 64'd1);
        repeat (30) tick();
        chk_eq("abort_recv_writes", 64'(wr_cnt), 64'd2);
        chk_eq("abort_recv_bursts", 64'(rd_cnt), 64'd1);
        chk_eq("abort_recv_beats_absorbed", 64'(resp_left), 64'd0);
        chk_eq("abort_recv_done", 64'(done_cnt), 64'd0);
        chk_eq("abort_recv_busy", 64'(busy), 64'd0);

        // Abort while draining pixels.
        setup(32'h100, 4, 2);
        pulse_start(32'h100, 4, 2);
        for (int i = 0; i < 500 && wr_cnt < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n0 = wr_cnt;
        chk_eq("abort_drain_wr_en", 64'(wr_en), 64'd0);
        chk_eq("abort_drain_busy", 64'(busy), 64'd0);
        repeat (30) tick();
        chk_eq("abort_drain_no_more_writes", 64'(wr_cnt), 64'(n0));
        chk_eq("abort_drain_done", 64'(done_cnt), 64'd0);

        // Reset in mid-drain, then a frame whose second row wraps the address space.
        setup(32'h100, 4, 2);
        pulse_start(32'h100, 4, 2);
        for (int i = 0; i < 500 && wr_cnt < 8; i++) tick();
        do_reset();
        run_full(32'h1FFFF0, 0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk_eq("lit_wrap_addr0", 64'(got_a.size() > 0 ? got_a[0] : '0), 64'h1FFFF0);
        chk_eq("lit_wrap_addr2", 64'(got_a.size() > 2 ? got_a[2] : '0), 64'h000004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
